// File: rtl/cga_alu_pkg.sv
// Shared constants for the CGA ALU data bus register.
// Default geometry and the FIFOEN encoding.
package cga_alu_pkg;

  localparam int DBR_WIDTH_DEF = 16;
  localparam int DBR_DEPTH_DEF = 4;

  localparam logic DBR_MODE_LEGACY = 1'b0;
  localparam logic DBR_MODE_FIFO   = 1'b1;

endpackage

// File: rtl/cga_alu_dbr_fifo_if.sv
// CD bus / ALU side signals of the data bus register.
// The master drives CD bus strobes and data; the slave (DBR) returns the head word and status.
interface cga_alu_dbr_fifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  logic [WIDTH-1:0]             CD_IN;
  logic                         LDDBRN;
  logic                         RDDBRN;
  logic                         FIFOEN;
  logic                         CLRERRN;
  logic [WIDTH-1:0]             DBR_OUT;
  logic                         DBREMPTY;
  logic                         DBRFULL;
  logic [$clog2(DEPTH+1)-1:0]   DBRCNT;
  logic                         DBROVF;
  logic                         DBRUNF;

  modport master (
    output CD_IN, LDDBRN, RDDBRN, FIFOEN, CLRERRN,
    input  DBR_OUT, DBREMPTY, DBRFULL, DBRCNT, DBROVF, DBRUNF
  );

  modport slave (
    input  CD_IN, LDDBRN, RDDBRN, FIFOEN, CLRERRN,
    output DBR_OUT, DBREMPTY, DBRFULL, DBRCNT, DBROVF, DBRUNF
  );
endinterface

// File: rtl/cga_alu_dbr_mem.sv
// DBR storage array: one synchronous write port, one asynchronous read port.
// No reset; contents are only meaningful between the FIFO pointers.
module cga_alu_dbr_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    wrAddr,
  input  logic [WIDTH-1:0] wrData,
  input  logic [PW-1:0]    rdAddr,
  output logic [WIDTH-1:0] rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wrAddr] <= wrData;
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/cga_alu_dbr_fifo.sv
// CGA ALU data bus register: legacy holding register or DEPTH-entry show-ahead FIFO.
// Pointers, occupancy, sticky error flags and the registered head word live here.
module cga_alu_dbr_fifo
  import cga_alu_pkg::*;
#(
  parameter int               WIDTH     = DBR_WIDTH_DEF,
  parameter int               DEPTH     = DBR_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic               ALUCLK,
  input  logic               RESETN,
  cga_alu_dbr_fifo_if.slave  dbr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]    wrPtr, rdPtr, nextRd;
  logic [CW-1:0]    cnt, nextCnt;
  logic             fifoEnQ;
  logic [WIDTH-1:0] dbrOut, memRd, headWord;
  logic             emptyQ, fullQ, ovfQ, unfQ;
  logic             modeChg, fifoAct, push, pop, empty, full;
  logic             doPush, doPop, ovfEv, unfEv;

  always_comb begin
    modeChg  = (dbr.FIFOEN != fifoEnQ);
    fifoAct  = (dbr.FIFOEN == DBR_MODE_FIFO) && !modeChg;
    push     = fifoAct && !dbr.LDDBRN;
    pop      = fifoAct && !dbr.RDDBRN;
    empty    = (cnt == '0);
    full     = (cnt == CW'(DEPTH));
    // At full a simultaneous pop frees the slot; at empty the pop has nothing to take.
    doPush   = push && (!full || pop);
    doPop    = pop && !empty;
    ovfEv    = push && full && !pop;
    unfEv    = pop && empty;
    nextRd   = rdPtr + PW'(doPop);
    nextCnt  = modeChg ? '0 : cnt + CW'(doPush) - CW'(doPop);
    // Word being written this edge is the new head when it lands at the next read slot.
    headWord = (doPush && (wrPtr == nextRd)) ? dbr.CD_IN : memRd;
  end

  cga_alu_dbr_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk    (ALUCLK),
    .we     (doPush && RESETN),
    .wrAddr (wrPtr),
    .wrData (dbr.CD_IN),
    .rdAddr (nextRd),
    .rdData (memRd)
  );

  always_ff @(posedge ALUCLK) begin
    if (!RESETN) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      cnt     <= '0;
      fifoEnQ <= DBR_MODE_LEGACY;
      dbrOut  <= RESET_VAL;
      emptyQ  <= 1'b1;
      fullQ   <= 1'b0;
      ovfQ    <= 1'b0;
      unfQ    <= 1'b0;
    end else begin
      fifoEnQ <= dbr.FIFOEN;
      if (modeChg) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (doPush) wrPtr <= wrPtr + PW'(1);
        if (doPop)  rdPtr <= nextRd;
      end
      cnt    <= nextCnt;
      emptyQ <= (nextCnt == '0);
      fullQ  <= (nextCnt == CW'(DEPTH));
      if (!modeChg) begin
        if (fifoAct) begin
          if (nextCnt != '0) dbrOut <= headWord;
        end else if (!dbr.LDDBRN) begin
          dbrOut <= dbr.CD_IN;
        end
      end
      ovfQ <= ovfEv || (ovfQ && dbr.CLRERRN);
      unfQ <= unfEv || (unfQ && dbr.CLRERRN);
    end
  end

  assign dbr.DBR_OUT  = dbrOut;
  assign dbr.DBRCNT   = cnt;
  assign dbr.DBREMPTY = emptyQ;
  assign dbr.DBRFULL  = fullQ;
  assign dbr.DBROVF   = ovfQ;
  assign dbr.DBRUNF   = unfQ;

endmodule
